// File: rtl/key_access_pkg.sv
// Shared types and sizing helpers for the password gate in front of the key stage.
package key_access_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DENY    = 2'd2,
        ST_LOCK    = 2'd3
    } state_e;

    // Width able to hold 0..max_fails inclusive.
    function automatic int fail_cnt_w(input int max_fails);
        return (max_fails < 1) ? 1 : $clog2(max_fails + 1);
    endfunction

    // Width of a counter covering 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_access_ctrl_lockout_timer.sv
// Down-counter for the lockout window: load to LOCKOUT_CYCLES-1, count while enabled, done at zero.
module lockout_timer
    import key_access_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CNT_W = idx_w(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/key_access_ctrl.sv
// Constant-time multi-word password check with consecutive-failure lockout.
module key_access_ctrl
    import key_access_pkg::*;
#(
    parameter int                   PW_WORDS       = 2,
    parameter logic [32*PW_WORDS-1:0] PASSWORD     = 64'hDEADBEEF_CAFEF00D,
    parameter int                   MAX_FAILS      = 3,
    parameter int                   LOCKOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    input  logic [31:0]                           req_word,
    input  logic                                  req_last,
    output logic                                  req_ready,
    output logic                                  access_granted,
    output logic                                  access_denied,
    output logic                                  locked,
    output logic [fail_cnt_w(MAX_FAILS)-1:0]      fail_count
);

    localparam int IDX_W = idx_w(PW_WORDS);
    localparam int FC_W  = fail_cnt_w(MAX_FAILS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_WORDS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAILS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);

    logic [WORD_W-1:0] pw_words [PW_WORDS];

    generate
        for (genvar gi = 0; gi < PW_WORDS; gi++) begin : g_pw_words
            assign pw_words[gi] = PASSWORD[WORD_W*gi +: WORD_W];
        end
    endgenerate

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mis_q, mis_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             granted_q, denied_q, locked_q;
    logic             timer_load, timer_done;
    logic             word_bad, mis_next, at_last;

    // The compare runs every cycle regardless of outcome so no path depends on the secret.
    assign word_bad = (req_word != pw_words[idx_q]);
    assign mis_next = mis_q | word_bad;
    assign at_last  = (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mis_d      = mis_q;
        fc_d       = fc_q;
        timer_load = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (req_valid) begin
                    mis_d = mis_next;
                    if (req_last || at_last) begin
                        idx_d   = '0;
                        state_d = (mis_next || (req_last != at_last)) ? ST_DENY : ST_GRANT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                fc_d    = '0;
                mis_d   = 1'b0;
                state_d = ST_COLLECT;
            end
            ST_DENY: begin
                mis_d = 1'b0;
                if (fc_q == FC_LAST) begin
                    fc_d       = FC_MAX;
                    timer_load = 1'b1;
                    state_d    = ST_LOCK;
                end else begin
                    fc_d    = fc_q + 1'b1;
                    state_d = ST_COLLECT;
                end
            end
            ST_LOCK: begin
                if (timer_done) begin
                    fc_d    = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            idx_q     <= '0;
            mis_q     <= 1'b0;
            fc_q      <= '0;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mis_q     <= mis_d;
            fc_q      <= fc_d;
            granted_q <= (state_d == ST_GRANT);
            denied_q  <= (state_d == ST_DENY);
            locked_q  <= (state_d == ST_LOCK);
        end
    end

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .en   (state_q == ST_LOCK),
        .done (timer_done)
    );

    assign req_ready      = (state_q == ST_COLLECT);
    assign access_granted = granted_q;
    assign access_denied  = denied_q;
    assign locked         = locked_q;
    assign fail_count     = fc_q;

endmodule

// File: tb/tb_key_access_ctrl.sv
// Randomized and directed checks of key_access_ctrl against a transaction-level model.
module tb_key_access_ctrl;

    localparam int          PW_WORDS       = 2;
    localparam logic [63:0] PASSWORD       = 64'hDEADBEEF_CAFEF00D;
    localparam int          MAX_FAILS      = 3;
    localparam int          LOCKOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_word = '0;
    logic        req_last = 1'b0;
    logic        req_ready;
    logic        access_granted;
    logic        access_denied;
    logic        locked;
    logic [1:0]  fail_count;

    int errors = 0;
    int checks = 0;
    int model_fc = 0;
    logic [63:0] pw = PASSWORD;
    logic [31:0] good0, good1;

    key_access_ctrl #(
        .PW_WORDS(PW_WORDS), .PASSWORD(PASSWORD),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_word(req_word),
        .req_last(req_last), .req_ready(req_ready), .access_granted(access_granted),
        .access_denied(access_denied), .locked(locked), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one word; the block must be ready since the model says it is collecting.
    task automatic drive_word(input logic [31:0] w, input logic l, input string name);
        @(negedge clk);
        req_valid = 1'b1;
        req_word  = w;
        req_last  = l;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_on_word: got %b want 1", name, req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_entry(input logic [31:0] w0, input logic l0,
                              input logic [31:0] w1, input logic l1,
                              input int n, input string name);
        logic ok, exp_lock;
        int   cnt, rdy_bad;
        ok = (w0 == good0) && ((n == 1) ? (l0 == (PW_WORDS == 1)) :
                               (!l0 && (w1 == good1) && (l1 == 1'b1)));
        exp_lock = 1'b0;
        if (ok) model_fc = 0;
        else begin
            model_fc++;
            if (model_fc == MAX_FAILS) exp_lock = 1'b1;
        end

        drive_word(w0, l0, name);
        if (n == 2) drive_word(w1, l1, name);
        // Outcome cycle: keep junk on the bus to confirm it is ignored.
        req_word = $urandom;
        req_last = 1'($urandom);
        checks++;
        if (access_granted !== ok || access_denied !== !ok || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s outcome: granted=%b denied=%b ready=%b want granted=%b denied=%b ready=0",
                     name, access_granted, access_denied, req_ready, ok, !ok);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (access_granted !== 1'b0 || access_denied !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: granted=%b denied=%b want 0 0", name, access_granted, access_denied);
        end
        if (exp_lock) begin
            checks++;
            if (locked !== 1'b1 || fail_count !== 2'(MAX_FAILS)) begin
                errors++;
                $display("FAIL %s lock_entry: locked=%b fail_count=%0d want 1 %0d",
                         name, locked, fail_count, MAX_FAILS);
            end
            cnt = 0;
            rdy_bad = 0;
            while (locked === 1'b1 && cnt < 100) begin
                if (req_ready !== 1'b0) rdy_bad++;
                req_valid = 1'b1;
                req_word  = good0;
                req_last  = 1'b0;
                cnt++;
                @(posedge clk);
                #1;
            end
            req_valid = 1'b0;
            checks++;
            if (cnt != LOCKOUT_CYCLES || rdy_bad != 0) begin
                errors++;
                $display("FAIL %s lock_len: cycles=%0d ready_high=%0d want %0d 0",
                         name, cnt, rdy_bad, LOCKOUT_CYCLES);
            end
            model_fc = 0;
        end
        checks++;
        if (locked !== 1'b0 || req_ready !== 1'b1 || fail_count !== 2'(model_fc)) begin
            errors++;
            $display("FAIL %s after: locked=%b ready=%b fail_count=%0d want 0 1 %0d",
                     name, locked, req_ready, fail_count, model_fc);
        end
        $display("entry %s words=%0d ok=%b lock=%b fail_count=%0d", name, n, ok, exp_lock, model_fc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || access_granted !== 1'b0 || access_denied !== 1'b0 ||
            locked !== 1'b0 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b g=%b d=%b locked=%b fc=%0d want 1 0 0 0 0",
                     req_ready, access_granted, access_denied, locked, fail_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_fc = 0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        $display("reset done");
    endtask

    task automatic test_correct();
        send_entry(good0, 1'b0, good1, 1'b1, 2, "correct");
    endtask

    task automatic test_wrong_word0();
        send_entry(32'h0000_0000, 1'b0, good1, 1'b1, 2, "wrong_word0");
    endtask

    task automatic test_framing();
        send_entry(good0, 1'b0, good1, 1'b1, 2, "clear");
        send_entry(good0, 1'b1, 32'h0, 1'b0, 1, "early_last");
        send_entry(good0, 1'b0, good1, 1'b0, 2, "missing_last");
    endtask

    task automatic test_lockout();
        send_entry(good0, 1'b0, good1, 1'b1, 2, "clear");
        send_entry(32'h1234_5678, 1'b0, good1, 1'b1, 2, "bad1");
        send_entry(good0, 1'b0, 32'hFFFF_FFFF, 1'b1, 2, "bad2");
        send_entry(good0, 1'b1, 32'h0, 1'b0, 1, "bad3");
        send_entry(good0, 1'b0, good1, 1'b1, 2, "post_lock");
    endtask

    task automatic test_recovery();
        send_entry(32'h1, 1'b0, good1, 1'b1, 2, "rbad1");
        send_entry(good0, 1'b0, 32'h2, 1'b1, 2, "rbad2");
        send_entry(good0, 1'b0, good1, 1'b1, 2, "rgood");
        send_entry(32'h3, 1'b0, 32'h4, 1'b1, 2, "rbad3");
    endtask

    task automatic test_reset_mid();
        int seen_grant;
        drive_word(good0, 1'b0, "mid_word0");
        seen_grant = 0;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        if (access_granted !== 1'b0) seen_grant++;
        @(negedge clk);
        rst_n = 1'b1;
        model_fc = 0;
        if (access_granted !== 1'b0) seen_grant++;
        checks++;
        if (seen_grant != 0 || fail_count !== 2'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_state: grants=%0d fc=%0d ready=%b want 0 0 1",
                     seen_grant, fail_count, req_ready);
        end
        send_entry(good1, 1'b1, 32'h0, 1'b0, 1, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] w0, w1;
        logic        l1;
        int          n;
        for (int i = 0; i < 40; i++) begin
            w0 = ($urandom_range(0, 3) != 0) ? good0 : $urandom;
            w1 = ($urandom_range(0, 3) != 0) ? good1 : $urandom;
            n  = ($urandom_range(0, 5) == 0) ? 1 : 2;
            l1 = ($urandom_range(0, 5) != 0);
            if (n == 1) send_entry(w0, 1'b1, 32'h0, 1'b0, 1, $sformatf("rand%0d", i));
            else        send_entry(w0, 1'b0, w1, l1, 2, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        good0 = pw[31:0];
        good1 = pw[63:32];
        test_reset();
        test_correct();
        test_wrong_word0();
        test_framing();
        test_lockout();
        test_recovery();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_access_ctrl.md
Name: key_access_ctrl

Overview:
- Upstream gate for the secret-key output stage. Collects a multi-word password over a valid/ready stream and compares it in constant time against a parameterised secret.
- Produces the access_granted level that the key stage samples, so the key appears for exactly one clock after a correct entry.
- Counts consecutive failures. After MAX_FAILS failures it enforces a timed lockout in which no input is accepted.

Parameters:
- PW_WORDS, 2: number of 32-bit words in one password entry (>=1).
- PASSWORD, 64'hDEADBEEF_CAFEF00D: secret, width 32*PW_WORDS; word i is compared against PASSWORD[32*i +: 32].
- MAX_FAILS, 3: consecutive failed entries that trigger lockout (>=1).
- LOCKOUT_CYCLES, 16: clock cycles spent in lockout (>=1).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- req_valid, input, 1: req_word/req_last valid this cycle.
- req_word, input, 32: password word.
- req_last, input, 1: marks the final word of an entry.
- req_ready, output, 1: block accepts a word this cycle.
- access_granted, output, 1: one-cycle pulse on a correct entry; drives the key stage.
- access_denied, output, 1: one-cycle pulse on a failed entry.
- locked, output, 1: high throughout lockout.
- fail_count, output, $clog2(MAX_FAILS+1): consecutive failures so far.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low.
  - State is COLLECT, word index = 0, mismatch flag = 0, lockout timer = 0, fail_count = 0.
  - access_granted, access_denied and locked are 0; req_ready is 1 in the first cycle after reset.
- Handshake: a word transfers when req_valid && req_ready. req_ready is 1 only in COLLECT and is combinational from state.
- COLLECT:
  - On each transfer, OR (req_word != expected word[idx]) into the mismatch flag.
  - Never exit early on a mismatch: every entry consumes the same number of words, so timing is constant.
  - Transfer with req_last = 1, or idx == PW_WORDS-1:
    - Entry ends, idx returns to 0.
    - Entry is a failure if mismatch, or if req_last != (idx == PW_WORDS-1).
    - So an early req_last fails, and a missing req_last on the final word fails.
    - Go to GRANT on success, DENY on failure.
  - Otherwise idx increments.
- GRANT, one cycle:
  - access_granted = 1, fail_count <= 0, mismatch cleared, next state COLLECT.
  - The key stage therefore sees access_granted high for exactly one clk.
- DENY, one cycle:
  - access_denied = 1, mismatch cleared.
  - If fail_count+1 == MAX_FAILS: go to LOCK and load the timer with LOCKOUT_CYCLES-1.
  - Otherwise increment fail_count and go to COLLECT.
- LOCK:
  - locked = 1, req_ready = 0, fail_count reads MAX_FAILS; the timer decrements each cycle.
  - At timer == 0: fail_count <= 0, go to COLLECT, so locked drops the next cycle.
  - Total locked-high duration is exactly LOCKOUT_CYCLES.
- Output registering: access_granted and access_denied are decoded from the state register. They are glitch-free and never high together.
- Latency: last-word transfer at cycle N gives access_granted/access_denied at N+1. req_ready returns at N+2 if no lockout follows.
- Input hygiene: req_valid with req_ready = 0 is ignored, and no state changes. req_word is don't-care when req_valid = 0.
- Reset mid-operation: a partial entry is discarded, lockout is cancelled and fail_count cleared. No access_granted pulse is generated by or around reset.
- Constraint: PASSWORD must never drive any output or be observable through timing.

Decomposition:
- Package key_access_pkg holds:
  - state enum: ST_COLLECT, ST_GRANT, ST_DENY, ST_LOCK;
  - WORD_W = 32;
  - helper function for the fail-counter width.
- One sub-module, lockout_timer: load, count-down, done flag; parameter LOCKOUT_CYCLES.

Test Plan:
- Correct entry: send CAFEF00D then DEADBEEF with last=1 -> access_granted=1 for one cycle at N+1, access_denied=0, fail_count=0.
- Wrong word 0: send 00000000 then DEADBEEF with last=1 -> both words accepted (no early exit), then access_denied pulse, fail_count=1.
- Framing errors:
  - CAFEF00D sent with last=1 -> denied.
  - Correct words with last=0 on word 1 -> denied.
- Lockout:
  - Three bad entries -> locked=1 for exactly 16 cycles with req_ready=0.
  - Words sent during lockout are ignored.
  - After lockout, fail_count=0 and a correct entry is granted.
- Recovery: two bad entries then a correct one -> grant, fail_count returns to 0; a fourth bad entry then gives fail_count=1, not lockout.
- Reset mid-entry: after CAFEF00D is accepted, pulse rst_n=0 for one cycle, then send DEADBEEF with last=1 -> denied, no grant pulse.
